fifo_bulk_arbiter: RTL
======================

// Module: fifo_bulk_arbiter
// PURPOSE
//  Drains NUM_CH bulk FIFOs (my_fifo instances, read side) into one output stream.
//  Uses round-robin arbitration between channels that report a full bulk ready.
//  Reads exactly BULK_OF_DATA words per grant, tagged with channel id and first/last markers.
//  Also collects sticky per-channel FIFO error flags; sits between the FIFO bank and the DMA/packetiser.
// PARAMETERS
//  DATA_WIDTH    32  word width, matches the FIFOs
//  BULK_OF_DATA  8   words per bulk (per grant), >=2
//  NUM_CH        4   number of FIFO channels, 2..16
//  CH_W          2   width of channel id, = clog2(NUM_CH)
// PORTS
//  clk            in   1                single clock (= FIFO rclk)
//  rst_n          in   1                asynchronous, active-low reset
//  ch_r_ready     in   NUM_CH           per-channel "bulk available" from the FIFOs
//  ch_rdata       in   NUM_CH*DATA_WIDTH  per-channel rdata; ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//  ch_r_enable    out  NUM_CH           per-channel read enable, one-hot or zero
//  ch_error_full  in   NUM_CH           FIFO overflow flags
//  ch_error_empty in   NUM_CH           FIFO underflow flags
//  out_ready      in   1                sink can accept a whole bulk (sampled only at bulk start)
//  out_data       out  DATA_WIDTH       output word
//  out_valid      out  1                out_data valid this cycle
//  out_first      out  1                first word of bulk (qualified by out_valid)
//  out_last       out  1                last word of bulk (qualified by out_valid)
//  out_ch         out  CH_W             channel of the current bulk
//  busy           out  1                state != IDLE
//  err_sticky     out  NUM_CH           latched error per channel
//  err_clear      in   1                clears err_sticky
//  bulk_count     out  32               completed bulks, wraps at 2^32
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; outputs ch_r_enable, out_valid, out_first, out_last,
//   out_ch, busy, err_sticky and bulk_count are all 0.
//   The reset is immediate, also mid-bulk; a partial bulk is dropped with no out_last.
//   last_grant resets to NUM_CH-1, so ch0 has first priority.
//  FSM: IDLE -> READ -> DRAIN -> IDLE.
//   IDLE: if out_ready=1 and |ch_r_ready, register grant as the first ready channel, searching
//     last_grant+1, +2, ... modulo NUM_CH; set beat=0; go to READ. Otherwise stay in IDLE.
//   READ: ch_r_enable[grant]=1 for exactly BULK_OF_DATA consecutive cycles (beat 0..B-1),
//     then go to DRAIN. No abort and no back-pressure inside a bulk.
//   DRAIN: single cycle; ch_r_enable=0; set last_grant=grant; go to IDLE.
//  Data path: FIFO read latency is 1, so out_valid = registered copy of |ch_r_enable.
//   out_data = ch_rdata slice selected by grant (combinational mux).
//   grant/out_ch are held constant from the READ entry through the DRAIN cycle.
//   out_first is set on the valid beat 0; out_last on the valid beat B-1, which falls in the DRAIN cycle.
//   bulk_count increments on the clock edge that ends DRAIN.
//  Timing: a bulk occupies B+1 cycles (READ + DRAIN), plus at least 1 IDLE cycle between bulks.
//   Minimum grant-to-grant spacing is B+2 cycles. IDLE arbitration reads ch_r_ready after the
//   FIFO read pointer has settled.
//  Fairness: a channel that has just been served gets lowest priority. A channel that stays ready
//   is served at least once every NUM_CH bulks.
//  Errors: err_sticky[i] is set in any cycle where ch_error_full[i] or ch_error_empty[i] is 1.
//   err_clear clears all bits; if set and clear occur in the same cycle, set wins.
//   Errors have no effect on sequencing.
//  out_ready is don't-care outside IDLE. ch_r_ready dropping during READ is ignored.
//  Arithmetic: beat is clog2(B)+1 bits wide; grant search wraps modulo NUM_CH; bulk_count wraps to 0.
// TESTING
//  1 Reset, ch_r_ready=4'b0100, out_ready=1 -> busy rises 1 cycle later; ch_r_enable=4'b0100
//    for 8 cycles; out_valid for 8 cycles offset by 1; out_ch=2; out_first/out_last on beats 0/7;
//    bulk_count=1.
//  2 ch_r_ready=4'b1111 held, 8 bulks -> out_ch sequence 0,1,2,3,0,1,2,3; grant spacing of 10 cycles.
//  3 out_ready=0 with ch_r_ready=4'b0001 -> stays IDLE, ch_r_enable=0; out_ready->1 starts
//    the bulk on the next edge.
//  4 rst_n pulled low at beat 3 of a bulk -> ch_r_enable, out_valid and busy drop immediately;
//    after release, ch0 gets priority again.
//  5 ch_error_empty[1] pulse, then err_clear with ch_error_full[3]=1 in the same cycle ->
//    err_sticky=0010, then 1000.
//  6 Data integrity: each FIFO is preloaded with a ramp tagged by channel (ch<<16|n) ->
//    out_data matches in order with no gaps or duplicates across 32 bulks.

Source files
------------

// File: rtl/fifo_bulk_arbiter_if.sv
// Bundle between the FIFO bank, the bulk arbiter and the downstream sink.
// master is the arbiter's view, slave the view of the surrounding logic.
interface fifo_bulk_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2
);
  logic [NUM_CH-1:0]            ch_r_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata;
  logic [NUM_CH-1:0]            ch_r_enable;
  logic [NUM_CH-1:0]            ch_error_full;
  logic [NUM_CH-1:0]            ch_error_empty;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_first;
  logic                         out_last;
  logic [CH_W-1:0]              out_ch;
  logic                         busy;
  logic [NUM_CH-1:0]            err_sticky;
  logic                         err_clear;
  logic [31:0]                  bulk_count;

  modport master (
    input  ch_r_ready,
    input  ch_rdata,
    input  ch_error_full,
    input  ch_error_empty,
    input  out_ready,
    input  err_clear,
    output ch_r_enable,
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    output out_ch,
    output busy,
    output err_sticky,
    output bulk_count
  );

  modport slave (
    output ch_r_ready,
    output ch_rdata,
    output ch_error_full,
    output ch_error_empty,
    output out_ready,
    output err_clear,
    input  ch_r_enable,
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    input  out_ch,
    input  busy,
    input  err_sticky,
    input  bulk_count
  );
endinterface

// File: rtl/fifo_bulk_arbiter.sv
// Round-robin bulk drain of NUM_CH FIFOs into one tagged stream,
// with sticky per-channel FIFO error capture.
module fifo_bulk_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int BULK_OF_DATA = 8,
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_bulk_arbiter_if.master bus
);

  localparam int BEAT_W = $clog2(BULK_OF_DATA) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(BULK_OF_DATA - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   CH_MOD  = (CH_W+1)'(NUM_CH);

  logic [1:0]            state;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       last_grant;
  logic [CH_W-1:0]       next_grant;
  logic                  found;
  logic [CH_W:0]         sum;
  logic [CH_W-1:0]       idx;
  logic [BEAT_W-1:0]     beat;
  logic [NUM_CH-1:0]     rd_en;
  logic                  valid_q;
  logic                  first_q;
  logic                  last_q;
  logic [NUM_CH-1:0]     err_q;
  logic [31:0]           bulk_q;
  logic [DATA_WIDTH-1:0] lane [NUM_CH];

  // search starts one past the last served channel, so it ranks lowest
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      sum = {1'b0, last_grant} + (CH_W+1)'(k);
      if (sum >= CH_MOD) sum = sum - CH_MOD;
      idx = sum[CH_W-1:0];
      if (!found && bus.ch_r_ready[idx]) begin
        next_grant = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    rd_en = '0;
    if (state == READ) rd_en[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_CH;
      beat       <= '0;
      bulk_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.out_ready && found) begin
            grant <= next_grant;
            beat  <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (beat == LAST_BEAT) state <= DRAIN;
          else beat <= beat + BEAT_W'(1);
        end
        DRAIN: begin
          last_grant <= grant;
          bulk_q     <= bulk_q + 32'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO read latency is one cycle: markers trail the enable by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= |rd_en;
      first_q <= (state == READ) && (beat == '0);
      last_q  <= (state == READ) && (beat == LAST_BEAT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= (err_q & ~{NUM_CH{bus.err_clear}})
             | bus.ch_error_full
             | bus.ch_error_empty;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign lane[i] = bus.ch_rdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.ch_r_enable = rd_en;
  assign bus.out_data    = lane[grant];
  assign bus.out_valid   = valid_q;
  assign bus.out_first   = first_q;
  assign bus.out_last    = last_q;
  assign bus.out_ch      = grant;
  assign bus.busy        = (state != IDLE);
  assign bus.err_sticky  = err_q;
  assign bus.bulk_count  = bulk_q;

endmodule
